// File: rtl/sequence_generator.sv
// Serial pattern generator: sends len bits of pattern MSB-first on w, framed by valid/busy/done.
// Optional macro SEQ_GEN_REPEAT_EN adds the rep port and back-to-back frame repetition.
module sequence_generator #(
    parameter int unsigned MAX_LEN = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [3:0]         len,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic [3:0]         rep,
`endif
    output logic               w,
    output logic               valid,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [3:0] MaxLenC = 4'(MAX_LEN);

    logic [1:0]         state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               w_q, w_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef SEQ_GEN_REPEAT_EN
    logic [3:0]         len_q, len_d;
    logic [3:0]         rep_cnt_q, rep_cnt_d;
`endif

    logic len_ok;

    // Variable bit select written as a compare loop so the 4-bit index never exceeds the vector.
    function automatic logic pick(input logic [MAX_LEN-1:0] v, input logic [3:0] idx);
        pick = 1'b0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (idx == 4'(i)) begin
                pick = v[i];
            end
        end
    endfunction

    assign len_ok = (len != 4'd0) && (len <= MaxLenC);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        w_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
        len_d     = len_q;
        rep_cnt_d = rep_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        pat_d   = pattern;
                        cnt_d   = len - 4'd1;
                        w_d     = pick(pattern, len - 4'd1);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
                        len_d     = len;
                        rep_cnt_d = rep;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d   = cnt_q - 4'd1;
                    w_d     = pick(pat_q, cnt_q - 4'd1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
                end else if (rep_cnt_q != 4'd0) begin
                    // Restart the frame in the very next cycle: no gap between repetitions.
                    rep_cnt_d = rep_cnt_q - 4'd1;
                    cnt_d     = len_q - 4'd1;
                    w_d       = pick(pat_q, len_q - 4'd1);
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
`endif
                end else begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            pat_q   <= '0;
            cnt_q   <= 4'd0;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
            len_q     <= 4'd0;
            rep_cnt_q <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SEQ_GEN_REPEAT_EN
            len_q     <= len_d;
            rep_cnt_q <= rep_cnt_d;
`endif
        end
    end

    assign w     = w_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: doc/sequence_generator.md
SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, giving the maximum pattern length in bits (2..15).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: frame request, sampled on each rising clk edge.
REQ-005 SHALL have port pattern, input, MAX_LEN bits: bits to transmit; bit len-1 is sent first, bit 0 last.
REQ-006 SHALL have port len, input, 4 bits: number of pattern bits to send; legal range 1..MAX_LEN.
REQ-007 SHALL have port rep, input, 4 bits: additional repetitions of the frame (present only with SEQ_GEN_REPEAT_EN).
REQ-008 SHALL have port w, output, 1 bit: serial data, suitable for driving a sequence detector's w input.
REQ-009 SHALL have port valid, output, 1 bit: w carries a pattern bit this cycle.
REQ-010 SHALL have port busy, output, 1 bit: frame in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a frame.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and FINISH; all outputs registered.
REQ-014 IDLE: on an edge with start=1 and 1<=len<=MAX_LEN, SHALL do all of the following:
- capture pattern, len and rep;
- drive w=pattern[len-1] with valid=1 and busy=1;
- load the bit counter with len-1;
- go to SHIFT.
The first bit is therefore visible in the cycle after the start edge (latency 1).
REQ-015 IDLE: on an edge with start=1 and len=0 or len>MAX_LEN, SHALL pulse err for one cycle, stay in IDLE, and leave w, valid and busy at 0.
REQ-016 SHIFT: each edge SHALL present the next lower captured bit on w and decrement the counter; a frame of len bits occupies exactly len consecutive valid cycles.
REQ-017 SHIFT with counter 0 and no repetitions remaining SHALL go to FINISH with w=0, valid=0, busy=0 and done=1.
REQ-018 FINISH SHALL last exactly one cycle, clear done, and go to IDLE; start is ignored in FINISH, so consecutive frames are separated by at least two idle cycles.
REQ-019 start, pattern, len and rep changes while busy=1 or in FINISH SHALL be ignored and SHALL NOT set err.
REQ-020 w SHALL be 0 whenever valid=0.
REQ-021 len=1 SHALL produce a single valid cycle followed by a done pulse.

Reset
REQ-022 resetn=0 SHALL asynchronously force state IDLE, w=0, valid=0, busy=0, done=0, err=0, and clear the counters and captured registers.
REQ-023 Reset mid-frame SHALL abort the frame with no done pulse; the first start after resetn rises SHALL behave as in REQ-014.

Configuration
REQ-024 Macro SEQ_GEN_REPEAT_EN defined: the rep port SHALL exist and the frame SHALL be sent rep+1 times back-to-back with no gap cycle; done SHALL pulse only after the final repetition.
REQ-025 SEQ_GEN_REPEAT_EN undefined: the rep port SHALL be absent and every frame SHALL be sent exactly once.

Verification
REQ-026 Bench SHALL cover: pattern=8'b00001011, len=4, start pulse at edge 0 -> w=1,0,1,1 with valid=1 on cycles 1-4; done=1 on cycle 5; busy=0 from cycle 5.
REQ-027 Bench SHALL cover: len=8, pattern=8'hA5 -> w=1,0,1,0,0,1,0,1 on cycles 1-8; done on cycle 9.
REQ-028 Bench SHALL cover: len=0, start=1 -> err=1 for one cycle; valid and busy stay 0; a following legal start is accepted normally.
REQ-029 Bench SHALL cover: start re-asserted on cycle 2 of a 4-bit frame -> ignored; output stream unchanged; exactly one done pulse.
REQ-030 Bench SHALL cover: resetn=0 on cycle 3 of pattern 1011 -> w, valid and busy immediately 0; no done pulse; after release, a new start sends the full frame.
REQ-031 Bench SHALL cover (SEQ_GEN_REPEAT_EN defined): pattern=2'b01, len=2, rep=2 -> w=0,1,0,1,0,1 on cycles 1-6; a single done pulse on cycle 7.
